// File: rtl/controle_pagamento.sv
// Payment/dispense controller: takes a confirmed selection, accumulates coin credit,
// pulses the dispense with the product code and holds change until acknowledged.
// Optional inactivity refund is compiled in with `define CONTROLE_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// OCIOSO  | idle; waits for a valid confirm; coins are refused
// PAGANDO | selection locked; accumulating credit toward the latched price
// LIBERA  | one-cycle dispense; decides between change and idle
// DEVOLVE | change/refund presented until the coin return acknowledges it
module controle_pagamento #(
  parameter int CREDITO_MAX    = 15,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] valor,
  input  logic [3:0] codeOut,
  input  logic       existe,
  input  logic       confirma,
  input  logic       moeda,
  input  logic [1:0] moeda_valor,
  input  logic       cancela,
  input  logic       troco_ack,
  output logic [3:0] credito,
  output logic [3:0] produto,
  output logic       libera,
  output logic [3:0] troco,
  output logic       troco_valido,
  output logic       rejeita,
  output logic       erro,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    PAGANDO = 2'b01,
    LIBERA  = 2'b10,
    DEVOLVE = 2'b11
  } estado_t;

  if (CREDITO_MAX < 1 || CREDITO_MAX > 15) begin : g_bad_credito_max
    $error("CREDITO_MAX must be in 1..15");
  end
  if (TIMEOUT_CICLOS < 1) begin : g_bad_timeout
    $error("TIMEOUT_CICLOS must be at least 1");
  end

  estado_t    r_estado;
  logic [2:0] r_preco;
  logic [3:0] r_prod;
  logic [3:0] r_credito;
  logic [3:0] r_produto;
  logic [3:0] r_troco;
  logic       r_libera;
  logic       r_troco_valido;
  logic       r_rejeita;
  logic       r_erro;

  logic [2:0] w_moeda_val;
  logic [4:0] w_soma;
  logic       w_moeda_ok;
  logic       w_cobre;
  logic [3:0] w_troco_lib;
  logic       w_sobra;
  logic       w_timeout;
  logic       w_cancela;

  always_comb begin
    w_moeda_val = 3'd0;
    case (moeda_valor)
      2'b01:   w_moeda_val = 3'd1;
      2'b10:   w_moeda_val = 3'd2;
      2'b11:   w_moeda_val = 3'd5;
      default: w_moeda_val = 3'd0;
    endcase
  end

  // 5-bit sum so an over-limit coin is refused instead of wrapping the credit.
  assign w_soma      = {1'b0, r_credito} + {2'b00, w_moeda_val};
  assign w_moeda_ok  = (w_moeda_val != 3'd0) && (w_soma <= 5'(CREDITO_MAX));
  assign w_cobre     = (w_soma >= {2'b00, r_preco});
  assign w_troco_lib = r_credito - {1'b0, r_preco};
  assign w_sobra     = (r_credito > {1'b0, r_preco});

`ifdef CONTROLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] r_timer;

  // Down-counter reloads whenever the customer shows activity or we leave PAGANDO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer <= TW'(TIMEOUT_CICLOS - 1);
    end else if (r_estado != PAGANDO || moeda || cancela) begin
      r_timer <= TW'(TIMEOUT_CICLOS - 1);
    end else if (r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  assign w_timeout = (r_estado == PAGANDO) && !moeda && !cancela && (r_timer == '0);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_cancela = cancela || w_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado       <= OCIOSO;
      r_preco        <= 3'd0;
      r_prod         <= 4'd0;
      r_credito      <= 4'd0;
      r_produto      <= 4'd0;
      r_troco        <= 4'd0;
      r_libera       <= 1'b0;
      r_troco_valido <= 1'b0;
      r_rejeita      <= 1'b0;
      r_erro         <= 1'b0;
    end else begin
      r_libera  <= 1'b0;
      r_rejeita <= 1'b0;
      r_erro    <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (moeda) r_rejeita <= 1'b1;
          if (confirma) begin
            if (existe && valor != 3'd0) begin
              r_preco  <= valor;
              r_prod   <= codeOut;
              r_estado <= PAGANDO;
            end else begin
              r_erro <= 1'b1;
            end
          end
        end
        PAGANDO: begin
          if (w_cancela) begin
            // A coin arriving with the cancel is refused; cancel wins.
            r_rejeita <= moeda;
            r_credito <= 4'd0;
            if (r_credito != 4'd0) begin
              r_troco        <= r_credito;
              r_troco_valido <= 1'b1;
              r_estado       <= DEVOLVE;
            end else begin
              r_estado <= OCIOSO;
            end
          end else if (moeda) begin
            if (w_moeda_ok) begin
              r_credito <= w_soma[3:0];
              if (w_cobre) begin
                r_libera  <= 1'b1;
                r_produto <= r_prod;
                r_estado  <= LIBERA;
              end
            end else begin
              r_rejeita <= 1'b1;
            end
          end
        end
        LIBERA: begin
          r_rejeita <= moeda;
          r_credito <= 4'd0;
          if (w_sobra) begin
            r_troco        <= w_troco_lib;
            r_troco_valido <= 1'b1;
            r_estado       <= DEVOLVE;
          end else begin
            r_estado <= OCIOSO;
          end
        end
        DEVOLVE: begin
          r_rejeita <= moeda;
          if (troco_ack) begin
            r_troco        <= 4'd0;
            r_troco_valido <= 1'b0;
            r_estado       <= OCIOSO;
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign credito      = r_credito;
  assign produto      = r_produto;
  assign libera       = r_libera;
  assign troco        = r_troco;
  assign troco_valido = r_troco_valido;
  assign rejeita      = r_rejeita;
  assign erro         = r_erro;
  assign estado       = r_estado;

endmodule

// File: tb/tb_controle_pagamento.sv
// Self-checking bench for controle_pagamento: directed scenarios plus randomized
// purchases checked against a transaction-level credit/change model.
module tb_controle_pagamento;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] valor;
  logic [3:0] codeOut;
  logic       existe;
  logic       confirma;
  logic       moeda;
  logic [1:0] moeda_valor;
  logic       cancela;
  logic       troco_ack;
  logic [3:0] credito;
  logic [3:0] produto;
  logic       libera;
  logic [3:0] troco;
  logic       troco_valido;
  logic       rejeita;
  logic       erro;
  logic [1:0] estado;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int ST_OCIOSO  = 0;
  localparam int ST_PAGANDO = 1;
  localparam int ST_LIBERA  = 2;
  localparam int ST_DEVOLVE = 3;
  localparam int MAX_CRED   = 15;

  controle_pagamento #(.CREDITO_MAX(15), .TIMEOUT_CICLOS(8)) dut (
    .clk(clk), .rst_n(rst_n), .valor(valor), .codeOut(codeOut), .existe(existe),
    .confirma(confirma), .moeda(moeda), .moeda_valor(moeda_valor), .cancela(cancela),
    .troco_ack(troco_ack), .credito(credito), .produto(produto), .libera(libera),
    .troco(troco), .troco_valido(troco_valido), .rejeita(rejeita), .erro(erro),
    .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int coin_units(input int d);
    case (d)
      1: return 1;
      2: return 2;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic confirm(input int v, input int c, input int e);
    valor = 3'(v); codeOut = 4'(c); existe = e[0]; confirma = 1'b1;
    tick();
    confirma = 1'b0;
  endtask

  task automatic coin(input int d);
    moeda = 1'b1; moeda_valor = 2'(d);
    tick();
    moeda = 1'b0; moeda_valor = 2'b00;
  endtask

  task automatic ack_change();
    troco_ack = 1'b1;
    tick();
    troco_ack = 1'b0;
    chk("ack_tv", troco_valido, 0);
    chk("ack_troco", troco, 0);
    chk("ack_estado", estado, ST_OCIOSO);
  endtask

  initial begin
    rst_n = 1'b0; valor = '0; codeOut = '0; existe = 1'b0; confirma = 1'b0;
    moeda = 1'b0; moeda_valor = '0; cancela = 1'b0; troco_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_estado", estado, ST_OCIOSO);
    chk("rst_credito", credito, 0);
    chk("rst_produto", produto, 0);
    chk("rst_troco", troco, 0);
    chk("rst_outs", {libera, troco_valido, rejeita, erro}, 0);

    coin(1);
    chk("idle_rejeita", rejeita, 1);
    chk("idle_credito", credito, 0);
    tick();
    chk("idle_rejeita_off", rejeita, 0);

    // exact payment
    confirm(6, 4'b0100, 1);
    chk("exact_estado", estado, ST_PAGANDO);
    coin(3);
    chk("exact_cred5", credito, 5);
    chk("exact_nolib", libera, 0);
    coin(1);
    chk("exact_cred6", credito, 6);
    chk("exact_libera", libera, 1);
    chk("exact_produto", produto, 4);
    tick();
    chk("exact_libera_off", libera, 0);
    chk("exact_tv", troco_valido, 0);
    chk("exact_estado_end", estado, ST_OCIOSO);
    chk("exact_cred_clr", credito, 0);

    // change
    confirm(1, 4'b1000, 1);
    coin(2);
    chk("chg_libera", libera, 1);
    chk("chg_produto", produto, 8);
    tick();
    chk("chg_estado", estado, ST_DEVOLVE);
    chk("chg_troco", troco, 1);
    chk("chg_tv", troco_valido, 1);
    chk("chg_credito", credito, 0);
    coin(3);
    chk("chg_coin_rej", rejeita, 1);
    tick(); tick();
    chk("chg_hold", troco, 1);
    chk("chg_hold_tv", troco_valido, 1);
    ack_change();

    // invalid selections
    confirm(3, 4'b1111, 0);
    chk("inv_erro", erro, 1);
    chk("inv_estado", estado, ST_OCIOSO);
    tick();
    chk("inv_erro_off", erro, 0);
    confirm(0, 4'b0010, 1);
    chk("inv0_erro", erro, 1);
    chk("inv0_estado", estado, ST_OCIOSO);

    // cancel priority over a simultaneous coin
    confirm(5, 4'b0011, 1);
    coin(2);
    coin(2);
    chk("sat_cred4", credito, 4);
    cancela = 1'b1; moeda = 1'b1; moeda_valor = 2'b11;
    tick();
    cancela = 1'b0; moeda = 1'b0; moeda_valor = 2'b00;
    chk("sat_rejeita", rejeita, 1);
    chk("sat_estado", estado, ST_DEVOLVE);
    chk("sat_troco", troco, 4);
    chk("sat_tv", troco_valido, 1);
    chk("sat_libera", libera, 0);
    ack_change();

    // invalid denomination, then zero-credit cancel
    confirm(3, 4'b0001, 1);
    coin(0);
    chk("den0_rejeita", rejeita, 1);
    chk("den0_credito", credito, 0);
    cancela = 1'b1; tick(); cancela = 1'b0;
    chk("cancel0_estado", estado, ST_OCIOSO);
    chk("cancel0_tv", troco_valido, 0);

    // selector changes after confirm are ignored
    confirm(2, 4'b0110, 1);
    valor = 3'd7; codeOut = 4'b1001; existe = 1'b0; confirma = 1'b1;
    tick();
    confirma = 1'b0;
    chk("lock_estado", estado, ST_PAGANDO);
    chk("lock_erro", erro, 0);
    coin(2);
    chk("lock_libera", libera, 1);
    chk("lock_produto", produto, 6);
    tick();
    chk("lock_estado_end", estado, ST_OCIOSO);

    // inactivity
    confirm(6, 4'b0101, 1);
    coin(2);
`ifdef CONTROLE_TIMEOUT_EN
    repeat (7) tick();
    chk("to_still_pag", estado, ST_PAGANDO);
    tick();
    chk("to_estado", estado, ST_DEVOLVE);
    chk("to_troco", troco, 2);
    chk("to_tv", troco_valido, 1);
    ack_change();
`else
    repeat (20) tick();
    chk("noto_estado", estado, ST_PAGANDO);
    chk("noto_credito", credito, 2);
    cancela = 1'b1; tick(); cancela = 1'b0;
    chk("noto_troco", troco, 2);
    ack_change();
`endif

    // randomized purchases against a credit/change model
    for (int t = 0; t < 40; t++) begin
      int price, code, credit, abort_at, ncoin, d, v, waitc;
      bit done;
      price    = $urandom_range(1, 7);
      code     = $urandom_range(0, 14);
      credit   = 0;
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      ncoin    = 0;
      done     = 1'b0;
      confirm(price, code, 1);
      chk("rnd_pagando", estado, ST_PAGANDO);
      while (!done) begin
        if (ncoin == abort_at) begin
          cancela = 1'b1; tick(); cancela = 1'b0;
          chk("rnd_cancel_credito", credito, 0);
          chk("rnd_cancel_tv", troco_valido, (credit != 0) ? 1 : 0);
          chk("rnd_cancel_estado", estado, (credit != 0) ? ST_DEVOLVE : ST_OCIOSO);
          if (credit != 0) begin
            chk("rnd_cancel_troco", troco, credit);
            ack_change();
          end
          done = 1'b1;
        end else begin
          if ($urandom_range(0, 3) == 0) tick();
          d = $urandom_range(0, 3);
          v = coin_units(d);
          valor = 3'($urandom); codeOut = 4'($urandom); existe = 1'($urandom);
          confirma = 1'($urandom);
          coin(d);
          confirma = 1'b0;
          ncoin++;
          if (v == 0 || credit + v > MAX_CRED) begin
            chk("rnd_rejeita", rejeita, 1);
            chk("rnd_cred_hold", credito, credit);
          end else begin
            credit += v;
            chk("rnd_credito", credito, credit);
            chk("rnd_no_rej", rejeita, 0);
            if (credit >= price) begin
              chk("rnd_libera", libera, 1);
              chk("rnd_produto", produto, code);
              tick();
              chk("rnd_libera_off", libera, 0);
              chk("rnd_cred_clr", credito, 0);
              if (credit > price) begin
                chk("rnd_chg_estado", estado, ST_DEVOLVE);
                chk("rnd_chg_troco", troco, credit - price);
                waitc = $urandom_range(0, 3);
                repeat (waitc) tick();
                chk("rnd_chg_tv", troco_valido, 1);
                ack_change();
              end else begin
                chk("rnd_end_estado", estado, ST_OCIOSO);
                chk("rnd_end_tv", troco_valido, 0);
              end
              done = 1'b1;
            end else begin
              chk("rnd_nolib", libera, 0);
            end
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
